// File: rtl/imem_program_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words, writes them to instruction memory,
// and holds the core in reset until the program is in. Optional trailing XOR checksum: define LOADER_CHECKSUM_EN.
module imem_program_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_loader_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         word_q, word_d;
  logic [15:0]         word_count_q, word_count_d;
  logic [ADDR_W-1:0]   im_waddr_q, im_waddr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic                byte_ready_q, byte_ready_d;
  logic                im_we_q, im_we_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                accept;
  logic [15:0]         len_rx;
  logic [15:0]         count_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  assign accept    = byte_valid & byte_ready_q;
  assign len_rx    = {len_q[15:8], byte_in};
  assign count_inc = (word_count_q == 16'hFFFF) ? word_count_q : word_count_q + 16'd1;

  // Next-state and datapath; handshake/status outputs are derived from the next state below
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    im_waddr_d   = im_waddr_q;
    im_wdata_d   = im_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LEN_HI;
          len_d        = 16'd0;
          byte_cnt_d   = 2'd0;
          word_count_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
          chk_d        = 8'd0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {byte_in, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d      = len_rx;
          byte_cnt_d = 2'd0;
          if (len_rx == 16'd0 || 32'(len_rx) > MAX_WORDS) state_d = S_ERR;
          else                                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ byte_in;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d    = S_WRITE;
            im_waddr_d = ADDR_W'(BASE_ADDR + 32'(word_count_q));
            im_wdata_d = {word_q[23:0], byte_in};
          end
        end
      end
      S_WRITE: begin
        word_count_d = count_inc;
`ifdef LOADER_CHECKSUM_EN
        state_d = (count_inc == len_q) ? S_CHK : S_DATA;
`else
        state_d = (count_inc == len_q) ? S_DONE : S_DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (byte_in == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                   || (state_d == S_CHK)
`endif
                   ;
    im_we_d   = (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERR);
    cpu_rst_d = (state_d != S_DONE);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
  end

  always_ff @(posedge clk or negedge rst_loader_n) begin
    if (!rst_loader_n) begin
      state_q      <= S_IDLE;
      len_q        <= 16'd0;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'd0;
      word_count_q <= 16'd0;
      im_waddr_q   <= '0;
      im_wdata_q   <= 32'd0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
      im_waddr_q   <= im_waddr_d;
      im_wdata_q   <= im_wdata_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = im_we_q;
  assign im_waddr   = im_waddr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: driver queues expected memory writes, monitor checks each im_we pulse.
module tb_imem_program_loader;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst_loader_n, start, byte_valid;
  logic [7:0]        byte_in;
  logic              byte_ready, im_we, cpu_rst, busy, done, error;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic [15:0]       word_count;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  imem_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_loader_n(rst_loader_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .im_we(im_we), .im_waddr(im_waddr),
    .im_wdata(im_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write, with the stream stalled
  always @(negedge clk) begin
    if (im_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected", im_waddr, im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(im_waddr), 32'(e.addr));
        check("write_data", im_wdata, e.data);
      end
      check("ready_during_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte 0x%0h never accepted, ready=%b expected 1", b, byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference: a length outside 1..MAX_WORDS aborts; otherwise word i lands at BASE_ADDR+i.
  task automatic run_load(input logic [15:0] len, input logic [31:0] words[$], input bit jitter,
                          input bit bad_chk);
    bit         len_ok;
    bit         ok;
    int         gap;
    int         n;
    logic [7:0] x;
    logic [7:0] b;
    len_ok = (len != 16'd0) && (32'(len) <= MAX_WORDS);
    ok     = len_ok;
    x      = 8'd0;
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("start_clears_done", 32'(done), 32'd0);
    check("start_clears_error", 32'(error), 32'd0);
    check("start_clears_count", 32'(word_count), 32'd0);
    send_byte(len[15:8], jitter ? int'($urandom_range(0, 1)) : 0);
    send_byte(len[7:0], jitter ? int'($urandom_range(0, 1)) : 0);
    if (len_ok) begin
      for (int i = 0; i < words.size(); i++) begin
        exp_q.push_back('{ADDR_W'(BASE_ADDR + 32'(i)), words[i]});
        for (int k = 0; k < 4; k++) begin
          b   = words[i][31 - 8*k -: 8];
          x   = x ^ b;
          gap = jitter ? int'($urandom_range(0, 1)) : 0;
          if (jitter && i == 0 && k == 2) gap = 5;
          send_byte(b, gap);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (x ^ 8'h01) : x, 0);
      ok = !bad_chk;
`endif
    end
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("load_finished", 32'(busy), 32'd0);
    check("done", 32'(done), 32'(ok));
    check("error", 32'(error), 32'(!ok));
    check("cpu_rst", 32'(cpu_rst), 32'(!ok));
    check("word_count", 32'(word_count), len_ok ? 32'(len) : 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    if (!bad_chk && x == 8'hFF) check("xor_unused", 32'(x), 32'hFF);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wq[$];
    logic [15:0] rl;
    rst_loader_n = 1'b0;
    start        = 1'b0;
    byte_valid   = 1'b0;
    byte_in      = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset_ready", 32'(byte_ready), 32'd0);
    check("reset_count", 32'(word_count), 32'd0);
    check("reset_waddr", 32'(im_waddr), 32'd0);
    rst_loader_n = 1'b1;

    // Idle with no start: core stays in reset, no writes, stream ignored
    byte_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c % 25 == 0) begin
        check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
      end
    end
    byte_valid = 1'b0;

    wq = '{32'h24080005, 32'h20090007};
    run_load(16'd2, wq, 1'b0, 1'b0);
    run_load(16'd2, wq, 1'b1, 1'b0);

    wq.delete();
    run_load(16'h0000, wq, 1'b0, 1'b0);
    run_load(16'h0401, wq, 1'b1, 1'b0);

    // Reset partway through a word: nothing may be written
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst_loader_n = 1'b0;
    #1;
    check("midload_rst_we", 32'(im_we), 32'd0);
    check("midload_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midload_rst_ready", 32'(byte_ready), 32'd0);
    check("midload_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_loader_n = 1'b1;
    @(negedge clk);
    wq = '{32'hDEADBEEF};
    run_load(16'd1, wq, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    wq = '{32'h11223344};
    run_load(16'd1, wq, 1'b0, 1'b0);
    run_load(16'd1, wq, 1'b0, 1'b1);
`endif

    for (int t = 0; t < 6; t++) begin
      rl = 16'($urandom_range(1, 6));
      wq.delete();
      for (int i = 0; i < int'(rl); i++) wq.push_back($urandom);
      run_load(rl, wq, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Largest legal program fills every address
    wq.delete();
    for (int i = 0; i < int'(MAX_WORDS); i++) wq.push_back($urandom);
    run_load(16'(MAX_WORDS), wq, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Boot-time stage directly upstream of the single-cycle core's instruction fetch unit.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the core's unit resets (pc/im/regFile/dm) asserted until the program has loaded cleanly.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- BASE_ADDR, 0, word address of the first loaded instruction.
- MAX_WORDS, 1024, largest legal program length in words; must be <= 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_loader_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory write enable.
- im_waddr  output  ADDR_W  instruction-memory word address.
- im_wdata  output  32  instruction word to write.
- cpu_rst  output  1  active-high reset, drives rst_pc/rst_im/rst_regFile/rst_dm.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully.
- error  output  1  last load aborted.
- word_count  output  16  words written in the current or last load.

Behaviour:
- Reset values (asynchronous): state=IDLE, byte_ready=0, im_we=0, im_waddr=0, im_wdata=0, cpu_rst=1, busy=0, done=0, error=0, word_count=0, internal length and byte counters=0.
- A byte is accepted only when byte_valid && byte_ready are both high at a rising edge.
- byte_ready=1 only in LEN_HI, LEN_LO, DATA (and CHK when the optional feature is enabled).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR (plus CHK when the optional feature is enabled).
- IDLE: on start go to LEN_HI, set busy=1, cpu_rst=1, clear done, error and word_count. All other inputs are ignored.
- LEN_HI / LEN_LO: accept the 16-bit length N, high byte first.
  - After LEN_LO, if N==0 or N>MAX_WORDS, go to ERR.
  - Otherwise go to DATA.
- DATA: shift accepted bytes into the word, first byte into [31:24]. After the 4th byte, go to WRITE; no byte is accepted in the WRITE cycle.
- WRITE (exactly 1 cycle):
  - im_we=1, im_waddr=BASE_ADDR+word_count (truncated to ADDR_W), im_wdata=assembled word.
  - On exit, word_count increments.
  - Go to DONE if the new word_count==N; otherwise return to DATA.
- Latency: im_we asserts in the cycle immediately after the edge that accepts a word's 4th byte.
- DONE: busy=0, done=1, cpu_rst=0 from the first DONE cycle onward.
- ERR: busy=0, error=1, cpu_rst remains 1. Words already written stay in memory.
- start while in DONE or ERR: restart exactly as from IDLE (cpu_rst re-asserts the next cycle). start while busy is ignored.
- Any state with byte_valid=0 simply waits. There is no timeout.
- Reset mid-load: all outputs return to reset values immediately. im_we drops asynchronously, so no partial word is written.
- word_count saturates at 16 bits; it cannot exceed MAX_WORDS by construction.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the N-th WRITE, go to CHK instead of DONE and accept one byte.
  - Compare it with the XOR of all 4N data bytes (length bytes excluded).
  - Match goes to DONE; mismatch goes to ERR.
  - done and cpu_rst release only after the checksum passes.
- Undefined: no CHK state, no XOR register; WRITE goes directly to DONE on the last word.

Test Plan:
- Reset with no start -> cpu_rst=1, byte_ready=0, im_we never pulses for 100 cycles.
- start; bytes 00 02 | 24 08 00 05 | 20 09 00 07 -> im_we pulses twice: addr 0 data 0x24080005, addr 1 data 0x20090007; then done=1, cpu_rst=0, word_count=2.
- Same stream with byte_valid toggled every other cycle and a 5-cycle gap mid-word -> identical writes. byte_ready=0 during each WRITE cycle and no byte is dropped.
- Length bytes 00 00, then separately 04 01 with MAX_WORDS=1024 -> ERR; error=1, cpu_rst stays 1, no im_we.
- rst_loader_n pulsed low after 2 data bytes, then a fresh start with length 1 and word DEADBEEF -> single write addr 0 data 0xDEADBEEF; the partial word is never written.
- LOADER_CHECKSUM_EN: length 1, word 11 22 33 44, checksum 44 -> done=1. Checksum 45 -> error=1, cpu_rst=1.
